// File: rtl/frame_pkg.sv
// Shared types and byte-update helpers for the USB return-path frame builder.
package frame_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SOF1,
    S_SOF2,
    S_CMD,
    S_LENH,
    S_LENL,
    S_DATA,
    S_CHK,
    S_GAP
  } frame_state_e;

  localparam logic [7:0] SOF1_DEFAULT = 8'hAA;
  localparam logic [7:0] SOF2_DEFAULT = 8'h55;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  // MSB-first CRC-8, polynomial x^8+x^2+x+1, one byte per call.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_tx_buf.sv
// Payload store for one frame: bytes written in order at the fill count, read back
// through an incrementing read pointer; clear rewinds both for the next frame.
module frame_tx_buf #(
  parameter  int MAX_LEN = 256,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_next,
  input  logic              clear,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [7:0]        rd_data
);

  logic [7:0]        mem_q [MAX_LEN];
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

  // NOTE: the storage array has no reset; only count and pointer define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= wr_data;
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      count_d  = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)   count_d  = count_q + 1'b1;
      if (rd_next) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/usb_frame_tx.sv
// Frame builder: buffers a payload, then emits SOF1 SOF2 CMD LEN_H LEN_L DATA.. CHK.
// Define FRAME_TX_CRC8_EN to make CHK a CRC-8 instead of the 8-bit additive sum.
module usb_frame_tx
  import frame_pkg::*;
#(
  parameter int         MAX_LEN    = 256,
  parameter logic [7:0] SOF1       = SOF1_DEFAULT,
  parameter logic [7:0] SOF2       = SOF2_DEFAULT,
  parameter int         GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

`ifdef FRAME_TX_CRC8_EN
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] data);
    return crc8_update(acc, data);
  endfunction
`else
  function automatic logic [7:0] chk_step(input logic [7:0] acc, input logic [7:0] data);
    return csum_update(acc, data);
  endfunction
`endif

  frame_state_e      state_q, state_d, ret_q, ret_d, nxt_state;
  logic [7:0]        cmd_q, cmd_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              buf_wr, buf_rd_next, buf_clear;
  logic [LEN_W-1:0]  buf_count;
  logic [ADDR_W-1:0] buf_rd_ptr;
  logic [7:0]        buf_rd_data;
  logic              hs, last_data;

  frame_tx_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (pl_data),
    .rd_next (buf_rd_next),
    .clear   (buf_clear),
    .count   (buf_count),
    .rd_ptr  (buf_rd_ptr),
    .rd_data (buf_rd_data)
  );

  assign last_data = (16'(buf_rd_ptr) + 16'd1) == len_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    chk_d       = chk_q;
    gap_d       = gap_q;
    nxt_state   = S_IDLE;
    pl_ready    = 1'b0;
    cmd_ready   = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    frame_done  = 1'b0;
    buf_wr      = 1'b0;
    buf_rd_next = 1'b0;
    buf_clear   = 1'b0;
    hs          = 1'b0;

    case (state_q)
      S_IDLE: begin
        pl_ready  = buf_count < MAX_CNT;
        cmd_ready = 1'b1;
        buf_wr    = pl_valid && pl_ready;
        if (cmd_valid) begin
          // A payload byte accepted in the same cycle belongs to this frame.
          cmd_d   = cmd;
          len_d   = 16'(buf_count) + 16'(buf_wr);
          chk_d   = 8'h00;
          state_d = S_SOF1;
        end
      end
      S_SOF1: begin out_valid = 1'b1; out_data = SOF1;        nxt_state = S_SOF2; end
      S_SOF2: begin out_valid = 1'b1; out_data = SOF2;        nxt_state = S_CMD;  end
      S_CMD:  begin out_valid = 1'b1; out_data = cmd_q;       nxt_state = S_LENH; end
      S_LENH: begin out_valid = 1'b1; out_data = len_q[15:8]; nxt_state = S_LENL; end
      S_LENL: begin
        out_valid = 1'b1;
        out_data  = len_q[7:0];
        nxt_state = (len_q == 16'd0) ? S_CHK : S_DATA;
      end
      S_DATA: begin
        out_valid   = 1'b1;
        out_data    = buf_rd_data;
        nxt_state   = last_data ? S_CHK : S_DATA;
        buf_rd_next = out_ready;
      end
      S_CHK: begin
        out_valid  = 1'b1;
        out_data   = chk_q;
        nxt_state  = S_IDLE;
        frame_done = out_ready;
        buf_clear  = out_ready;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = ret_q;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    hs = out_valid && out_ready;
    if (hs) begin
      if (state_q inside {S_CMD, S_LENH, S_LENL, S_DATA}) chk_d = chk_step(chk_q, out_data);
      if (GAP_CYCLES > 0) begin
        state_d = S_GAP;
        ret_d   = nxt_state;
        gap_d   = '0;
      end else begin
        state_d = nxt_state;
      end
    end

    // The trailing gap after CHK is not part of the frame for busy.
    busy = (state_q != S_IDLE) && !(state_q == S_GAP && ret_q == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      cmd_q   <= 8'h00;
      len_q   <= 16'h0000;
      chk_q   <= 8'h00;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_usb_frame_tx.sv
// Scoreboard bench for usb_frame_tx: a default instance and a GAP_CYCLES=10 instance.
module tb_usb_frame_tx;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] pl_data = '0, cmd = '0, out_data;
  logic       pl_valid = 0, cmd_valid = 0, out_ready = 1;
  logic       pl_ready, cmd_ready, out_valid, busy, frame_done;

  logic [7:0] g_pl_data = '0, g_cmd = '0, g_out_data;
  logic       g_pl_valid = 0, g_cmd_valid = 0, g_out_ready = 1;
  logic       g_pl_ready, g_cmd_ready, g_out_valid, g_busy, g_frame_done;

  usb_frame_tx dut (
    .clk(clk), .rst(rst),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done)
  );

  usb_frame_tx #(.MAX_LEN(16), .GAP_CYCLES(10)) dut_g (
    .clk(clk), .rst(rst),
    .pl_data(g_pl_data), .pl_valid(g_pl_valid), .pl_ready(g_pl_ready),
    .cmd(g_cmd), .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready),
    .out_data(g_out_data), .out_valid(g_out_valid), .out_ready(g_out_ready),
    .busy(g_busy), .frame_done(g_frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  exp_t qa[$], qb[$];
  logic [7:0] plm_a[$], plm_b[$];
  bit   rdy_rand = 0;
  bit   stall_a = 0;
  logic [7:0] stall_d_a = '0;
  int   pops_a = 0;
  bit   gap_on = 0, trail_on = 0;
  int   gap_cnt = 0, trail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] acc, input logic [7:0] d);
`ifdef FRAME_TX_CRC8_EN
    logic [7:0] c;
    c = acc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
`else
    return acc + d;
`endif
  endfunction

  task automatic push_exp(input bit g, input logic [7:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    if (g) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Builds the expected byte stream from the modelled payload, then empties the model.
  task automatic push_frame(input bit g, input logic [7:0] c);
    logic [7:0] p[$];
    logic [15:0] len;
    logic [7:0] chk;
    p   = g ? plm_b : plm_a;
    len = 16'(p.size());
    push_exp(g, 8'hAA, 0);
    push_exp(g, 8'h55, 0);
    push_exp(g, c, 0);
    push_exp(g, len[15:8], 0);
    push_exp(g, len[7:0], 0);
    chk = model_step(8'h00, c);
    chk = model_step(chk, len[15:8]);
    chk = model_step(chk, len[7:0]);
    foreach (p[i]) begin
      push_exp(g, p[i], 0);
      chk = model_step(chk, p[i]);
    end
    push_exp(g, chk, 1);
    if (g) plm_b.delete();
    else   plm_a.delete();
  endtask

  task automatic monitor();
    exp_t e;
    if (rst) return;
    if (stall_a) begin
      check("stall_valid", out_valid, 1);
      if (out_valid) check("stall_data", out_data, stall_d_a);
    end
    stall_a   = out_valid && !out_ready;
    stall_d_a = out_data;
    if (out_valid && out_ready) begin
      check("sb_a_has_entry", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("out_data", out_data, e.d);
        check("frame_done", frame_done, e.last);
        pops_a++;
      end
    end else if (frame_done) begin
      check("frame_done_no_hs", frame_done, 0);
    end

    if (trail_on) begin
      if (g_cmd_ready) begin
        check("trail_gap", trail_cnt, 10);
        trail_on = 0;
      end else trail_cnt++;
    end
    if (gap_on) begin
      if (g_out_valid) begin
        check("gap_len", gap_cnt, 10);
        gap_on = 0;
      end else gap_cnt++;
    end
    if (g_out_valid && g_out_ready) begin
      check("sb_g_has_entry", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("g_out_data", g_out_data, e.d);
        check("g_frame_done", g_frame_done, e.last);
        if (e.last) begin trail_on = 1; trail_cnt = 0; end
        else        begin gap_on = 1;   gap_cnt = 0;   end
      end
    end
  endtask

  task automatic tick();
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pl(input bit g, input logic [7:0] b, input bit exp_rdy);
    if (g) begin
      g_pl_data = b; g_pl_valid = 1;
      check("g_pl_ready", g_pl_ready, exp_rdy);
      if (exp_rdy) plm_b.push_back(b);
      tick();
      g_pl_valid = 0;
    end else begin
      pl_data = b; pl_valid = 1;
      check("pl_ready", pl_ready, exp_rdy);
      if (exp_rdy) plm_a.push_back(b);
      tick();
      pl_valid = 0;
    end
  endtask

  task automatic send_cmd(input bit g, input logic [7:0] c);
    push_frame(g, c);
    if (g) begin
      g_cmd = c; g_cmd_valid = 1;
      check("g_cmd_ready", g_cmd_ready, 1);
      tick();
      g_cmd_valid = 0;
      check("g_busy", g_busy, 1);
    end else begin
      cmd = c; cmd_valid = 1;
      check("cmd_ready", cmd_ready, 1);
      tick();
      cmd_valid = 0;
      pl_valid  = 0;
      check("sof_latency", out_valid, 1);
      check("busy", busy, 1);
      check("pl_ready_busy", pl_ready, 0);
    end
  endtask

  task automatic wait_done(input bit g, input int budget);
    int n = 0;
    while (n < budget && !(g ? (qb.size() == 0 && g_cmd_ready) : (qa.size() == 0 && cmd_ready))) begin
      tick();
      n++;
    end
    check(g ? "drain_g" : "drain", n < budget, 1);
  endtask

  initial begin
    int n;
    #12 rst = 0;
    @(posedge clk); #1;

    check("rst_out_valid", out_valid, 0);
    check("rst_pl_ready", pl_ready, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    // PWM echo
    send_pl(0, 8'h01, 1); send_pl(0, 8'h03, 1); send_pl(0, 8'hE8, 1);
    send_pl(0, 8'h01, 1); send_pl(0, 8'hF4, 1);
    send_cmd(0, 8'hFE);
    wait_done(0, 100);
    check("idle_busy", busy, 0);

    // Heartbeat, empty payload
    send_cmd(0, 8'hFF);
    wait_done(0, 100);

    // Backpressure on the PWM echo frame
    rdy_rand = 1;
    send_pl(0, 8'h01, 1); send_pl(0, 8'h03, 1); send_pl(0, 8'hE8, 1);
    send_pl(0, 8'h01, 1); send_pl(0, 8'hF4, 1);
    send_cmd(0, 8'hFE);
    wait_done(0, 2000);
    rdy_rand = 0;

    // Payload byte and command in the same cycle
    send_pl(0, 8'h10, 1);
    pl_data = 8'h77; pl_valid = 1;
    plm_a.push_back(8'h77);
    send_cmd(0, 8'h42);
    wait_done(0, 100);

    // Full buffer: the 257th byte is refused
    for (int i = 0; i < 257; i++) send_pl(0, i[7:0], i < 256);
    send_cmd(0, 8'h5A);
    wait_done(0, 1000);

    // Reset while the second data byte is offered
    send_pl(0, 8'h11, 1); send_pl(0, 8'h22, 1); send_pl(0, 8'h33, 1);
    send_pl(0, 8'h44, 1); send_pl(0, 8'h55, 1);
    pops_a = 0;
    send_cmd(0, 8'h07);
    n = 0;
    while (pops_a < 6 && n < 100) begin tick(); n++; end
    check("reach_data2", pops_a, 6);
    check("data2_valid", out_valid, 1);
    rst = 1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_pl_ready", pl_ready, 1);
    check("abort_cmd_ready", cmd_ready, 1);
    qa.delete();
    stall_a = 0;
    #3 rst = 0;
    @(posedge clk); #1;
    send_cmd(0, 8'h09);
    wait_done(0, 100);

    // Inter-byte and trailing gaps on the GAP_CYCLES=10 instance
    send_pl(1, 8'h10, 1); send_pl(1, 8'h20, 1);
    send_cmd(1, 8'h33);
    wait_done(1, 500);
    tick();
    check("trail_seen", trail_on, 0);
    check("gap_pending", gap_on, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
